// File: rtl/piradma_mm2s_burst_gen.sv
// Splits per-descriptor MM2S read commands into AXI4 INCR read bursts that stay inside 4 KB pages,
// with an outstanding-burst limit tracked from R-channel last beats.
module piradma_mm2s_burst_gen #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 32,
  parameter int unsigned DATA_BYTES      = 8,
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_tvalid,
  output logic                  cmd_tready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic                  m_rvalid,
  input  logic                  m_rready,
  input  logic                  m_rlast,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned SizeLg = $clog2(DATA_BYTES);
  localparam int unsigned OutW   = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {StIdle, StCalc, StIssue, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [LEN_WIDTH-1:0]  rem_beats_q, rem_beats_d;
  logic [8:0]            beats_q, beats_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [OutW-1:0]       out_q, out_d;

  logic [LEN_WIDTH-1:0]  cmd_beats;
  logic [12:0]           page_beats;
  logic [8:0]            burst_lim;
  logic                  ar_hs, r_last_hs;

  // Round up by adding the "any partial beat" bit, so an all-ones length cannot overflow.
  assign cmd_beats  = (cmd_len >> SizeLg)
                    + LEN_WIDTH'((cmd_len & LEN_WIDTH'(DATA_BYTES - 1)) != '0);
  assign page_beats = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> SizeLg;

  assign m_arvalid  = (state_q == StIssue) && (out_q < OutW'(MAX_OUTSTANDING));
  assign ar_hs      = m_arvalid & m_arready;
  assign r_last_hs  = m_rvalid & m_rready & m_rlast & (out_q != '0);

  always_comb begin
    burst_lim = 9'(MAX_BURST);
    if (page_beats < {4'd0, burst_lim}) burst_lim = page_beats[8:0];
  end

  always_comb begin
    unique case ({ar_hs, r_last_hs})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    rem_beats_d = rem_beats_q;
    beats_d     = beats_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_tvalid) begin
          cur_addr_d  = cmd_addr & ~ADDR_WIDTH'(DATA_BYTES - 1);
          rem_beats_d = cmd_beats;
          state_d     = (cmd_beats == '0) ? StDone : StCalc;
        end
      end
      StCalc: begin
        beats_d  = (rem_beats_q < LEN_WIDTH'(burst_lim)) ? rem_beats_q[8:0] : burst_lim;
        araddr_d = cur_addr_q;
        arlen_d  = 8'(beats_d - 9'd1);
        state_d  = StIssue;
      end
      StIssue: begin
        if (ar_hs) begin
          cur_addr_d  = cur_addr_q + (ADDR_WIDTH'(beats_q) << SizeLg);
          rem_beats_d = rem_beats_q - LEN_WIDTH'(beats_q);
          state_d     = (rem_beats_q == LEN_WIDTH'(beats_q)) ? StDrain : StCalc;
        end
      end
      // Look at the next count so the final rlast moves straight to DONE.
      StDrain: if (out_d == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      rem_beats_q <= '0;
      beats_q     <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      rem_beats_q <= rem_beats_d;
      beats_q     <= beats_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      out_q       <= out_d;
    end
  end

  assign cmd_tready = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign m_araddr   = araddr_q;
  assign m_arlen    = arlen_q;
  assign m_arsize   = 3'(SizeLg);
  assign m_arburst  = 2'b01;

endmodule

// File: tb/tb_piradma_mm2s_burst_gen.sv
// Randomized bench for piradma_mm2s_burst_gen: a page/burst splitting model predicts every AR
// and the done pulse; R-channel last beats are injected against a modelled outstanding count.
module tb_piradma_mm2s_burst_gen;

  localparam int unsigned DB = 8;
  localparam int unsigned MB = 16;
  localparam int unsigned MO = 4;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_tvalid, cmd_tready;
  logic [31:0] cmd_addr, cmd_len;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_arready;
  logic        m_rvalid, m_rready, m_rlast;
  logic        busy, done;

  always #5 aclk = ~aclk;

  piradma_mm2s_burst_gen #(
    .ADDR_WIDTH      (32),
    .LEN_WIDTH       (32),
    .DATA_BYTES      (DB),
    .MAX_BURST       (MB),
    .MAX_OUTSTANDING (MO)
  ) u_dut (
    .aclk       (aclk),
    .areset     (areset),
    .cmd_tvalid (cmd_tvalid),
    .cmd_tready (cmd_tready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .m_araddr   (m_araddr),
    .m_arlen    (m_arlen),
    .m_arsize   (m_arsize),
    .m_arburst  (m_arburst),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready),
    .m_rlast    (m_rlast),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned beats;
  } burst_t;

  burst_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     out_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Split a command into bursts: whole beats, at most MB each, never past a 4 KB page end.
  function automatic void plan(input logic [31:0] addr, input logic [31:0] len);
    longint unsigned a, left, n;
    a    = addr - (addr % DB);
    left = (longint'(len) + DB - 1) / DB;
    while (left > 0) begin
      n = (4096 - (a % 4096)) / DB;
      if (n > MB) n = MB;
      if (n > left) n = left;
      exp_q.push_back('{addr: a[31:0], beats: int'(n)});
      a    = (a + n * DB) % (64'd1 << 32);
      left = left - n;
    end
  endfunction

  task automatic run_cmd(input logic [31:0] addr, input logic [31:0] len, input int rdy_pct,
                         input int rl_start, input int stall);
    int          nb, issued, stall_left, waited;
    bit          done_exp, seen_done, prev_wait, rl;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;
    burst_t      b;
    exp_q.delete();
    plan(addr, len);
    nb = exp_q.size();
    waited = 0;
    while (!cmd_tready && waited < 100) begin
      step();
      waited++;
    end
    check_eq("cmd_ready", cmd_tready, 1);
    cmd_tvalid = 1'b1;
    cmd_addr   = addr;
    cmd_len    = len;
    step();
    cmd_tvalid = 1'b0;
    done_exp   = (nb == 0);
    issued     = 0;
    seen_done  = 1'b0;
    prev_wait  = 1'b0;
    stall_left = stall;
    for (int c = 1; c <= 4000 && !seen_done; c++) begin
      check_eq("done", done, done_exp);
      if (done) begin
        seen_done = 1'b1;
      end else begin
        check_eq("busy_rdy", {busy, cmd_tready}, 2'b10);
        if (c == 1) check_eq("lat_calc", m_arvalid, 0);
        if (c == 2 && nb > 0) check_eq("lat_issue", m_arvalid, 1);
        if (c == rl_start && rl_start >= 20) check_eq("thr_cnt", issued, (nb < MO) ? nb : MO);
        if (out_cnt == MO) check_eq("throttle", m_arvalid, 0);
        if (prev_wait)
          check_eq("ar_hold", {m_arvalid, m_araddr, m_arlen}, {1'b1, prev_addr, prev_len});
        if (m_arvalid && stall_left > 0) begin
          m_arready = 1'b0;
          stall_left--;
        end else begin
          m_arready = ($urandom_range(1, 100) <= rdy_pct);
        end
        rl = (out_cnt > 0) && (c >= rl_start) && ($urandom_range(0, 1) == 1);
        if (rl) begin
          m_rvalid = 1'b1;
          m_rready = 1'b1;
          m_rlast  = 1'b1;
        end else begin
          m_rvalid = 1'($urandom_range(0, 1));
          m_rready = 1'b0;
          m_rlast  = 1'($urandom_range(0, 1));
        end
        prev_wait = m_arvalid && !m_arready;
        prev_addr = m_araddr;
        prev_len  = m_arlen;
        if (m_arvalid && m_arready) begin
          if (exp_q.size() == 0) begin
            check_eq("ar_count", issued + 1, nb);
          end else begin
            b = exp_q.pop_front();
            check_eq("araddr", m_araddr, b.addr);
            check_eq("arlen", m_arlen, b.beats - 1);
            check_eq("arsize", m_arsize, 3);
            check_eq("arburst", m_arburst, 1);
          end
          issued++;
          out_cnt++;
        end
        if (rl) out_cnt--;
        done_exp = rl && (issued == nb) && (out_cnt == 0);
        step();
      end
    end
    check_eq("completed", seen_done, 1);
    check_eq("all_issued", issued, nb);
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rready  = 1'b0;
    m_rlast   = 1'b0;
    step();
    check_eq("post_idle", {busy, done, cmd_tready, m_arvalid}, 4'b0010);
  endtask

  initial begin
    int issued;
    areset     = 1'b1;
    cmd_tvalid = 1'b0;
    cmd_addr   = '0;
    cmd_len    = '0;
    m_arready  = 1'b0;
    m_rvalid   = 1'b0;
    m_rready   = 1'b0;
    m_rlast    = 1'b0;
    step();
    step();
    check_eq("reset", {cmd_tready, m_arvalid, busy, done, m_araddr, m_arlen}, {4'b1000, 40'h0});
    areset = 1'b0;
    step();

    run_cmd(32'h0000_1000, 32'd128, 100, 3, 0);
    run_cmd(32'h0000_0FF0, 32'd64, 100, 3, 0);
    run_cmd(32'h0000_1003, 32'd20, 100, 3, 0);
    run_cmd(32'h0000_0000, 32'd1024, 100, 40, 0);
    run_cmd(32'h0000_2000, 32'd64, 100, 3, 5);
    run_cmd(32'h0000_3000, 32'd0, 100, 3, 0);
    run_cmd(32'hFFFF_FF80, 32'd256, 100, 3, 0);

    // Huge command: first bursts must appear, then reset lands mid-ISSUE with two outstanding.
    cmd_tvalid = 1'b1;
    cmd_addr   = 32'h0;
    cmd_len    = 32'hFFFF_FFFF;
    m_arready  = 1'b1;
    step();
    cmd_tvalid = 1'b0;
    issued     = 0;
    for (int c = 0; c < 20 && !(issued == 2 && m_arvalid); c++) begin
      if (m_arvalid) begin
        check_eq("rst_araddr", m_araddr, issued * 128);
        check_eq("rst_arlen", m_arlen, 15);
        issued++;
      end
      step();
    end
    check_eq("rst_pre", {m_arvalid, busy, 6'(issued)}, {2'b11, 6'd2});
    #1 areset = 1'b1;
    #1;
    check_eq("rst_async", {m_arvalid, busy, cmd_tready, done, m_araddr, m_arlen}, {4'b0010, 40'h0});
    m_arready = 1'b0;
    out_cnt   = 0;
    step();
    step();
    areset = 1'b0;
    step();
    run_cmd(32'h0000_0000, 32'd1024, 100, 40, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] l;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
      l = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 700));
      run_cmd(a, l, $urandom_range(30, 100), $urandom_range(1, 10), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
